// File: rtl/pixel_addr_pkg.sv
// Shared types for the pixel address generator: FSM state encoding and latched run configuration.
package pixel_addr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic cont;
    logic scale2x;
  } cfg_t;

  function automatic logic is_busy(input state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/pixel_tick_sync.sv
// Brings the asynchronous pixel clock into the clk domain and emits a 1-clk tick per rising edge.
module pixel_tick_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic s_rst,
  input  logic pixel_clk,
  output logic tick
);

  logic s1, s2, s3;

  // s1/s2 form the metastability chain; s3 only delays s2 for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (s_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pixel_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/pixel_addr_gen.sv
// Frame-buffer read-address generator: raster (x,y) walk with linear address, line/frame strobes,
// 2x upscale, one-shot/continuous and pause. Ping-pong buffering is enabled by FRAME_PINGPONG_EN.
module pixel_addr_gen
  import pixel_addr_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = H_ACTIVE * V_ACTIVE,
  localparam int X_W        = $clog2(H_ACTIVE),
  localparam int Y_W        = $clog2(V_ACTIVE)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              s_rst,
  input  logic              enable,
  input  logic              pixel_clk,
  input  logic              cont,
  input  logic              scale2x,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              line_done,
  output logic              frame_done,
  output logic              busy,
  output logic              buf_sel,
  output state_t            fsm_state
);

  localparam logic [X_W-1:0]    X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_HALF = ADDR_W'(H_ACTIVE / 2);
  localparam logic [ADDR_W-1:0] FW     = ADDR_W'(FRAME_WORDS);

  // Handshake: there is none in the valid/ready sense; tick is a single-cycle event that the
  // generator consumes only while in RUN with enable high, and every output is registered.

  logic tick;

  pixel_tick_sync u_tick_sync (
    .clk       (clk),
    .n_rst     (n_rst),
    .s_rst     (s_rst),
    .pixel_clk (pixel_clk),
    .tick      (tick)
  );

  state_t            state, state_n;
  cfg_t              cfg, cfg_n;
  logic [X_W-1:0]    x_n;
  logic [Y_W-1:0]    y_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic              line_done_n, frame_done_n;
  logic              buf_q, buf_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cfg        <= '0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      addr       <= '0;
      base_q     <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      buf_q      <= 1'b0;
    end else if (s_rst) begin
      state      <= IDLE;
      cfg        <= '0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      addr       <= '0;
      base_q     <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      buf_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cfg        <= cfg_n;
      x          <= x_n;
      y          <= y_n;
      row_base   <= row_base_n;
      addr       <= addr_n;
      base_q     <= base_n;
      line_done  <= line_done_n;
      frame_done <= frame_done_n;
      buf_q      <= buf_n;
    end
  end

  always_comb begin
    state_n      = state;
    cfg_n        = cfg;
    x_n          = x;
    y_n          = y;
    row_base_n   = row_base;
    addr_n       = addr;
    base_n       = base_q;
    line_done_n  = 1'b0;
    frame_done_n = 1'b0;
    buf_n        = buf_q;

    case (state)
      IDLE: begin
        x_n        = '0;
        y_n        = '0;
        buf_n      = 1'b0;
        addr_n     = base_addr;
        row_base_n = base_addr;
        base_n     = base_addr;
        if (enable) begin
          state_n       = RUN;
          cfg_n.cont    = cont;
          cfg_n.scale2x = scale2x;
        end
      end

      RUN: begin
        if (!enable) begin
          state_n = PAUSE;
        end else if (tick) begin
          if (x != X_LAST) begin
            x_n = x + X_W'(1);
          end else begin
            x_n         = '0;
            line_done_n = 1'b1;
            if (y != Y_LAST) begin
              y_n = y + Y_W'(1);
              // In upscale mode each source row is shown twice, so advance only after odd lines.
              row_base_n = row_base + (cfg.scale2x ? (y[0] ? H_HALF : '0) : H_STEP);
            end else begin
              y_n          = '0;
              frame_done_n = 1'b1;
              base_n       = base_addr;
              if (cfg.cont) begin
                cfg_n.cont    = cont;
                cfg_n.scale2x = scale2x;
`ifdef FRAME_PINGPONG_EN
                buf_n = ~buf_q;
`else
                buf_n = 1'b0;
`endif
                row_base_n = base_addr + (buf_n ? FW : '0);
              end else begin
                state_n    = DONE;
                buf_n      = 1'b0;
                row_base_n = base_addr;
              end
            end
          end
          addr_n = row_base_n + (cfg_n.scale2x ? ADDR_W'(x_n >> 1) : ADDR_W'(x_n));
        end
      end

      PAUSE: begin
        if (enable) begin
          state_n = RUN;
        end
      end

      DONE: begin
        x_n    = '0;
        y_n    = '0;
        buf_n  = 1'b0;
        addr_n = base_q;
        if (!enable) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = is_busy(state);
  assign buf_sel   = buf_q;
  assign fsm_state = state;

endmodule
